// File: rtl/cam_match_resolver_if.sv
// Bundle between the CAM search stage, the match resolver and the hit consumer.
// The slave side is the resolver; the master side is whatever drives searches and takes hits.
interface cam_match_resolver_if #(
  parameter int DEPTH = 16
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] match_in;
  logic             search_valid;
  logic             search_ready;
  logic             hit_valid;
  logic             hit_ready;
  logic [IDX_W-1:0] hit_index;
  logic             hit_last;
  logic [CNT_W-1:0] hit_count;
  logic             miss;

  modport slave (
    input  match_in, search_valid, hit_ready,
    output search_ready, hit_valid, hit_index, hit_last, hit_count, miss
  );

  modport master (
    output match_in, search_valid, hit_ready,
    input  search_ready, hit_valid, hit_index, hit_last, hit_count, miss
  );
endinterface

// File: rtl/cam_match_resolver.sv
// Captures a CAM match vector on a search strobe and streams out the matching
// entry indices lowest first, with a last flag, a hit count and a miss pulse.
module cam_match_resolver #(
  parameter int DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  cam_match_resolver_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             miss_q, miss_d;

  logic [IDX_W-1:0] low_idx;
  logic [DEPTH-1:0] pending_minus1;
  logic             single;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // x & (x-1) both tests for a single set bit and clears the lowest one.
  always_comb begin
    low_idx        = '0;
    pending_minus1 = pending_q - DEPTH'(1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
    single = (pending_q != '0) && ((pending_q & pending_minus1) == '0);
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    hit_count_d = hit_count_q;
    miss_d      = 1'b0;
    if (state_q == IDLE) begin
      if (bus.search_valid) begin
        pending_d   = bus.match_in;
        hit_count_d = popcount(bus.match_in);
        if (bus.match_in != '0) begin
          state_d = DRAIN;
        end else begin
          miss_d = 1'b1;
        end
      end
    end else begin
      if (bus.hit_ready) begin
        pending_d = pending_q & pending_minus1;
        if (single) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      hit_count_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      hit_count_q <= hit_count_d;
      miss_q      <= miss_d;
    end
  end

  // pending is always zero in IDLE, so low_idx naturally reads 0 there.
  assign bus.search_ready = (state_q == IDLE);
  assign bus.hit_valid    = (state_q == DRAIN);
  assign bus.hit_index    = low_idx;
  assign bus.hit_last     = (state_q == DRAIN) && single;
  assign bus.hit_count    = hit_count_q;
  assign bus.miss         = miss_q;
endmodule

// File: tb/tb_cam_match_resolver.sv
// Self-checking bench for cam_match_resolver: directed vector table, hand-written
// reset-mid-drain sequence, then random traffic against an index-queue model.
module tb_cam_match_resolver;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  cam_match_resolver_if #(.DEPTH(DEPTH)) bus ();

  cam_match_resolver #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] match;
    logic        sv;
    logic        hr;
    logic        e_sr;
    logic        e_hv;
    int          e_idx;
    logic        e_last;
    int          e_cnt;
    logic        e_miss;
  } vec_t;

  int passed;
  int total;

  // Model: outstanding matched indices kept as a plain queue, lowest first.
  int q[$];
  int m_cnt;
  bit m_miss;

  function automatic void modelStep(input logic r, input logic [15:0] m,
                                    input logic sv, input logic hr);
    m_miss = 1'b0;
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else if (q.size() == 0) begin
      if (sv) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m[i]) q.push_back(i);
        end
        m_cnt  = q.size();
        m_miss = (q.size() == 0);
      end
    end else if (hr) begin
      void'(q.pop_front());
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic [15:0] m,
                               input logic sv, input logic hr);
    rst              = r;
    bus.match_in     = m;
    bus.search_valid = sv;
    bus.hit_ready    = hr;
    modelStep(r, m, sv, hr);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("[TB] FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic checkOutput(input string tag, input logic sr, input logic hv,
                             input int idx, input logic last, input int cnt,
                             input logic miss);
    cmp({tag, ".search_ready"}, int'(bus.search_ready), int'(sr));
    cmp({tag, ".hit_valid"},    int'(bus.hit_valid),    int'(hv));
    cmp({tag, ".hit_index"},    int'(bus.hit_index),    idx);
    cmp({tag, ".hit_last"},     int'(bus.hit_last),     int'(last));
    cmp({tag, ".hit_count"},    int'(bus.hit_count),    cnt);
    cmp({tag, ".miss"},         int'(bus.miss),         int'(miss));
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, q.size() == 0, q.size() != 0,
                (q.size() != 0) ? q[0] : 0, q.size() == 1, m_cnt, m_miss);
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] m;
    logic        r, sv, hr;
    passed = 0;
    total  = 0;
    m_cnt  = 0;
    m_miss = 1'b0;
    rst              = 1'b1;
    bus.match_in     = '0;
    bus.search_valid = 1'b0;
    bus.hit_ready    = 1'b0;

    //          rst  match     sv hr   sr hv idx last cnt miss
    vecs.push_back('{1, 16'h0000, 0, 0, 1, 0, 0,  0,  0, 0});
    vecs.push_back('{1, 16'h0000, 0, 0, 1, 0, 0,  0,  0, 0});
    vecs.push_back('{0, 16'h0001, 1, 1, 0, 1, 0,  1,  1, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 1, 0, 0,  0,  1, 0});
    vecs.push_back('{0, 16'h8421, 1, 1, 0, 1, 0,  0,  4, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 0, 1, 5,  0,  4, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 0, 1, 10, 0,  4, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 0, 1, 15, 1,  4, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 1, 0, 0,  0,  4, 0});
    vecs.push_back('{0, 16'h0005, 1, 0, 0, 1, 0,  0,  2, 0});
    vecs.push_back('{0, 16'hFFFF, 1, 0, 0, 1, 0,  0,  2, 0});
    vecs.push_back('{0, 16'hFFFF, 1, 0, 0, 1, 0,  0,  2, 0});
    vecs.push_back('{0, 16'hFFFF, 1, 0, 0, 1, 0,  0,  2, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 0, 1, 2,  1,  2, 0});
    vecs.push_back('{0, 16'h0000, 0, 1, 1, 0, 0,  0,  2, 0});
    vecs.push_back('{0, 16'h0000, 1, 1, 1, 0, 0,  0,  0, 1});
    vecs.push_back('{0, 16'h0000, 1, 1, 1, 0, 0,  0,  0, 1});
    vecs.push_back('{0, 16'h0000, 0, 1, 1, 0, 0,  0,  0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].match, vecs[i].sv, vecs[i].hr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_sr, vecs[i].e_hv,
                  vecs[i].e_idx, vecs[i].e_last, vecs[i].e_cnt, vecs[i].e_miss);
    end

    // Full vector, three hits taken, then reset mid-drain and a fresh search.
    applyStimulus(0, 16'hFFFF, 1, 1);
    checkOutput("full.cap", 1'b0, 1'b1, 0, 1'b0, 16, 1'b0);
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("full.h1", 1'b0, 1'b1, 1, 1'b0, 16, 1'b0);
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("full.h2", 1'b0, 1'b1, 2, 1'b0, 16, 1'b0);
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("full.h3", 1'b0, 1'b1, 3, 1'b0, 16, 1'b0);
    applyStimulus(1, 16'h0000, 0, 1);
    checkOutput("full.rst", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    applyStimulus(0, 16'h0100, 1, 1);
    checkOutput("post.cap", 1'b0, 1'b1, 8, 1'b1, 1, 1'b0);
    applyStimulus(0, 16'h0000, 0, 1);
    checkOutput("post.idle", 1'b1, 1'b0, 0, 1'b0, 1, 1'b0);

    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       m = 16'h0000;
        1:       m = 16'h0001 << $urandom_range(0, 15);
        2:       m = 16'($urandom);
        default: m = 16'hFFFF;
      endcase
      r  = ($urandom_range(0, 49) == 0);
      sv = ($urandom_range(0, 2) != 0);
      hr = ($urandom_range(0, 3) != 0);
      applyStimulus(r, m, sv, hr);
      checkModel($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
